ldm_stm_sequencer: RTL and testbench

Multi-cycle block-transfer sequencer for the single-cycle ARM datapath. It executes LDM/STM by walking a 16-bit register list, one register per cycle. It acts as the initiator on the register file's ports: the async read port (A1/RD1) on stores, and the synchronous write port (A3/WD3/WE) on loads. It drives the data-memory address, write-data and write-enable in step, and reports the updated base address.

---
 rtl/ldm_stm_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: walks a 16-bit register list, one register per cycle.
// Optional base writeback cycle: define SEQ_WRITEBACK_EN.
module ldm_stm_sequencer #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int WORD_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              load,
  input  logic              up,
  input  logic [ADDR_W-1:0] base,
  input  logic [15:0]       reglist,
  input  logic [3:0]        rn,
  output logic [3:0]        rf_a1,
  input  logic [DATA_W-1:0] rf_rd1,
  output logic [3:0]        rf_a3,
  output logic [DATA_W-1:0] rf_wd3,
  output logic              rf_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] wb_addr
);

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    WB,
    DONE
  } state_t;

  state_t            state;
  logic              load_q;
  logic [15:0]       pending;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] wb_q;
  logic              busy_q;
  logic              done_q;

  logic [4:0]        count;
  logic [ADDR_W-1:0] span;
  logic [ADDR_W-1:0] a0;
  logic [ADDR_W-1:0] wb_next;
  logic [3:0]        cur;
  logic [15:0]       rest;

`ifdef SEQ_WRITEBACK_EN
  logic [3:0]        rn_q;
  logic              skip_q;
`else
  logic              unused_rn;
  assign unused_rn = ^rn;
`endif

  always_comb begin
    count = '0;
    for (int i = 0; i < 16; i++) begin
      count = count + 5'(reglist[i]);
    end
  end

  assign span    = STRIDE * ADDR_W'(count);
  assign a0      = up ? base : base - span;
  assign wb_next = up ? base + span : base - span;

  // Lowest-numbered pending register goes first.
  always_comb begin
    cur = '0;
    for (int i = 15; i >= 0; i--) begin
      if (pending[i]) cur = 4'(i);
    end
  end

  assign rest = pending & (pending - 16'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      load_q  <= 1'b0;
      pending <= '0;
      addr_q  <= '0;
      wb_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_WRITEBACK_EN
      rn_q    <= '0;
      skip_q  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            load_q  <= load;
            pending <= reglist;
            addr_q  <= a0;
            wb_q    <= wb_next;
            busy_q  <= 1'b1;
`ifdef SEQ_WRITEBACK_EN
            rn_q    <= rn;
            skip_q  <= load & reglist[rn];
`endif
            if (count != 5'd0) begin
              state <= XFER;
            end else begin
`ifdef SEQ_WRITEBACK_EN
              state  <= WB;
`else
              state  <= DONE;
              done_q <= 1'b1;
`endif
            end
          end
        end
        XFER: begin
          pending <= rest;
          addr_q  <= addr_q + STRIDE;
          if (rest == 16'd0) begin
`ifdef SEQ_WRITEBACK_EN
            if (skip_q) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state  <= WB;
            end
`else
            state  <= DONE;
            done_q <= 1'b1;
`endif
          end
        end
        WB: begin
          state  <= DONE;
          done_q <= 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // Strobes drop while reset is held so an aborted transfer never commits.
  always_comb begin
    rf_a1    = '0;
    rf_a3    = '0;
    rf_wd3   = '0;
    rf_we    = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    mem_we   = 1'b0;
    unique case (state)
      XFER: begin
        mem_addr = addr_q;
        if (load_q) begin
          rf_a3  = cur;
          rf_wd3 = mem_rd;
          rf_we  = rst_n;
        end else begin
          rf_a1  = cur;
          mem_wd = rf_rd1;
          mem_we = rst_n;
        end
      end
      WB: begin
`ifdef SEQ_WRITEBACK_EN
        rf_a3  = rn_q;
        rf_wd3 = DATA_W'(wb_q);
        rf_we  = rst_n;
`endif
      end
      default: begin
      end
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign wb_addr = wb_q;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Bench for ldm_stm_sequencer: directed and random LDM/STM runs against a list-based model.
// Expectations follow SEQ_WRITEBACK_EN when defined.
module tb_ldm_stm_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        load;
  logic        up;
  logic [31:0] base;
  logic [15:0] reglist;
  logic [3:0]  rn;
  logic [3:0]  rf_a1;
  logic [31:0] rf_rd1;
  logic [3:0]  rf_a3;
  logic [31:0] rf_wd3;
  logic        rf_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;
  logic        busy;
  logic        done;
  logic [31:0] wb_addr;

  int checks = 0;
  int failures = 0;

  logic [31:0] rf [16];
  logic [31:0] rf_init [16];
  logic        rf_fill = 1'b0;

  always #5 clk = ~clk;

  ldm_stm_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load(load),
    .up(up), .base(base), .reglist(reglist), .rn(rn),
    .rf_a1(rf_a1), .rf_rd1(rf_rd1), .rf_a3(rf_a3),
    .rf_wd3(rf_wd3), .rf_we(rf_we), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd),
    .busy(busy), .done(done), .wb_addr(wb_addr)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h1F8) return 32'h11;
    if (a == 32'h1FC) return 32'h22;
    return ~a ^ 32'h1234_5678;
  endfunction

  assign mem_rd = mem_fn(mem_addr);
  assign rf_rd1 = rf[rf_a1];

  always @(posedge clk) begin
    if (rf_fill) begin
      for (int i = 0; i < 16; i++) rf[i] <= rf_init[i];
    end else if (rf_we) begin
      rf[rf_a3] <= rf_wd3;
    end
  end

  function automatic logic [107:0] obs();
    return {busy, done, rf_we, mem_we, rf_a1, rf_a3,
            rf_wd3, mem_addr, mem_wd};
  endfunction

  task automatic randomize_rf();
    for (int i = 0; i < 16; i++) rf_init[i] = $urandom;
  endtask

  task automatic scramble();
    load    = 1'($urandom);
    up      = 1'($urandom);
    base    = $urandom;
    reglist = 16'($urandom);
    rn      = 4'($urandom);
  endtask

  task automatic run_seq(input logic ld, input logic upd,
                         input logic [31:0] b, input logic [15:0] rl,
                         input logic [3:0] r, input bit hold,
                         input string nm);
    logic [3:0]   regs[$];
    logic [31:0]  shadow [16];
    logic [31:0]  expf [16];
    logic [31:0]  a0, wbx, ad;
    logic [107:0] ev, ov;
    int n, wbc, total;
    for (int i = 0; i < 16; i++) if (rl[i]) regs.push_back(4'(i));
    n   = regs.size();
    a0  = upd ? b : b - 32'(4 * n);
    wbx = upd ? b + 32'(4 * n) : b - 32'(4 * n);
    wbc = 0;
`ifdef SEQ_WRITEBACK_EN
    wbc = (ld && rl[r]) ? 0 : 1;
`endif
    total = n + wbc + 1;
    @(negedge clk);
    rf_fill = 1'b1;
    @(negedge clk);
    rf_fill = 1'b0;
    shadow  = rf_init;
    start   = 1'b1;
    load    = ld;
    up      = upd;
    base    = b;
    reglist = rl;
    rn      = r;
    for (int c = 1; c <= total + 1; c++) begin
      @(negedge clk);
      ev = '0;
      if (c <= n) begin
        ad = a0 + 32'(4 * (c - 1));
        if (ld)
          ev = {4'b1010, 4'h0, regs[c-1], mem_fn(ad), ad, 32'h0};
        else
          ev = {4'b1001, regs[c-1], 4'h0, 32'h0, ad, shadow[regs[c-1]]};
      end else if (c <= n + wbc) begin
        ev = {4'b1010, 4'h0, r, wbx, 64'h0};
      end else if (c == total) begin
        ev = {2'b11, 106'h0};
      end
      ov = obs();
      checks++;
      if (ov !== ev) begin
        failures++;
        $display("FAIL %s cycle %0d outputs: got %h want %h", nm, c, ov, ev);
      end
      if (c == total) begin
        checks++;
        if (wb_addr !== wbx) begin
          failures++;
          $display("FAIL %s wb_addr: got %h want %h", nm, wb_addr, wbx);
        end
      end
      start = (hold && c <= total) ? 1'b1 : 1'b0;
      scramble();
    end
    expf = shadow;
    if (ld) begin
      for (int k = 0; k < n; k++) expf[regs[k]] = mem_fn(a0 + 32'(4 * k));
    end
    if (wbc != 0) expf[r] = wbx;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rf[i] !== expf[i]) begin
        failures++;
        $display("FAIL %s R%0d: got %h want %h", nm, i, rf[i], expf[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    scramble();
    rf_fill = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({obs(), wb_addr} !== 140'h0) begin
      failures++;
      $display("FAIL reset outputs: got %h want 0", {obs(), wb_addr});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_stm_plan();
    randomize_rf();
    rf_init[0] = 32'hA;
    rf_init[2] = 32'hB;
    rf_init[4] = 32'hC;
    run_seq(1'b0, 1'b1, 32'h100, 16'h0015, 4'd9, 1'b0, "stm_up");
  endtask

  task automatic test_ldm_plan();
    randomize_rf();
    run_seq(1'b1, 1'b0, 32'h200, 16'h8002, 4'd7, 1'b0, "ldm_down");
  endtask

  task automatic test_empty();
    randomize_rf();
    run_seq(1'b0, 1'b1, 32'h4440, 16'h0000, 4'd2, 1'b0, "empty_stm");
    randomize_rf();
    run_seq(1'b1, 1'b0, 32'h880, 16'h0000, 4'd5, 1'b0, "empty_ldm");
  endtask

  task automatic test_wrap();
    randomize_rf();
    run_seq(1'b0, 1'b1, 32'hFFFF_FFFC, 16'h0003, 4'd8, 1'b0, "wrap_up");
    randomize_rf();
    run_seq(1'b1, 1'b0, 32'h4, 16'h0003, 4'd8, 1'b0, "wrap_down");
  endtask

  task automatic test_hold_start();
    randomize_rf();
    run_seq(1'b0, 1'b1, 32'h1000, 16'h0F0F, 4'd1, 1'b1, "hold_stm");
    randomize_rf();
    run_seq(1'b1, 1'b1, 32'h2000, 16'h00F0, 4'd2, 1'b1, "hold_ldm");
  endtask

  task automatic test_writeback();
    randomize_rf();
    run_seq(1'b1, 1'b1, 32'h300, 16'h000C, 4'd3, 1'b0, "wb_skip");
    randomize_rf();
    run_seq(1'b1, 1'b1, 32'h300, 16'h0003, 4'd3, 1'b0, "wb_write");
  endtask

  task automatic test_abort();
    logic [15:0] rl;
    logic [3:0]  first;
    logic [31:0] b, a0;
    logic [31:0] expf [16];
    logic        upd;
    rl = '0;
    while ($countones(rl) < 4) rl[$urandom_range(15, 0)] = 1'b1;
    first = '0;
    for (int i = 15; i >= 0; i--) if (rl[i]) first = 4'(i);
    b   = $urandom & 32'hFFFF_FFF0;
    upd = 1'($urandom);
    a0  = upd ? b : b - 32'd16;
    randomize_rf();
    @(negedge clk);
    rf_fill = 1'b1;
    @(negedge clk);
    rf_fill = 1'b0;
    expf    = rf_init;
    expf[first] = mem_fn(a0);
    start   = 1'b1;
    load    = 1'b1;
    up      = upd;
    base    = b;
    reglist = rl;
    rn      = 4'($urandom);
    @(negedge clk);
    checks++;
    if ({rf_we, rf_a3, mem_addr} !== {1'b1, first, a0}) begin
      failures++;
      $display("FAIL abort first xfer: got %h want %h",
               {rf_we, rf_a3, mem_addr}, {1'b1, first, a0});
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rf_we, mem_we} !== 2'b00) begin
      failures++;
      $display("FAIL abort strobes in reset: got %b want 00", {rf_we, mem_we});
    end
    @(negedge clk);
    checks++;
    if ({obs(), wb_addr} !== 140'h0) begin
      failures++;
      $display("FAIL abort outputs: got %h want 0", {obs(), wb_addr});
    end
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rf[i] !== expf[i]) begin
        failures++;
        $display("FAIL abort R%0d: got %h want %h", i, rf[i], expf[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] rl;
    logic [31:0] b;
    for (int i = 0; i < 24; i++) begin
      rl = 16'($urandom);
      if (i % 6 == 0) rl = 16'h0000;
      if (i % 6 == 1) rl = 16'hFFFF;
      b = $urandom;
      if (i % 5 == 2) b = 32'hFFFF_FFF0 | (b & 32'hC);
      randomize_rf();
      run_seq(1'($urandom), 1'($urandom), b, rl, 4'($urandom),
              (i % 3) == 0, "random");
    end
  endtask

  task automatic test_back_to_back();
    randomize_rf();
    run_seq(1'b0, 1'b0, 32'h5000, 16'h1248, 4'd6, 1'b1, "b2b_a");
    run_seq(1'b1, 1'b1, 32'h5000, 16'h1248, 4'd3, 1'b1, "b2b_b");
  endtask

  initial begin
    test_reset();
    test_stm_plan();
    test_ldm_plan();
    test_empty();
    test_wrap();
    test_hold_start();
    test_abort();
    test_writeback();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
